mux_nx1_rr: RTL and testbench

MUX_NX1_RR -- requirements
Module: mux_nx1_rr

---
 rtl/mux_nx1_rr.sv | 84 ++++++++
 tb/tb_mux_nx1_rr.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_rr.sv
// N-to-1 registered multiplexer with a single output slot; channel chosen either
// directly by index or by a round-robin arbiter that resumes after the last winner.
module mux_nx1_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N*WIDTH-1:0]   i_data,
  input  logic [N-1:0]         i_valid,
  output logic [N-1:0]         o_ready,
  input  logic                 i_mode,
  input  logic [SEL_W-1:0]     i_sel,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_valid,
  output logic [SEL_W-1:0]     o_src,
  input  logic                 i_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gidx;
  logic             gnt;
  logic             free;
  logic             xfer;
  logic [WIDTH-1:0] gdata;

  // base + step modulo N; base < N and step <= N, so one subtraction suffices
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= N) s = s - N;
    return SEL_W'(s);
  endfunction

  always_comb begin
    gnt  = 1'b0;
    gidx = '0;
    if (!i_mode) begin
      for (int k = 0; k < N; k++) begin
        if (i_sel == SEL_W'(k) && i_valid[k]) begin
          gnt  = 1'b1;
          gidx = SEL_W'(k);
        end
      end
    end else begin
      // scan from the far end so the nearest candidate after ptr wins last
      for (int k = N; k >= 1; k--) begin
        if (i_valid[next_idx(ptr, k)]) begin
          gnt  = 1'b1;
          gidx = next_idx(ptr, k);
        end
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int k = 0; k < N; k++) begin
      if (gidx == SEL_W'(k)) gdata = i_data[k*WIDTH +: WIDTH];
    end
  end

  assign free    = ~o_valid | i_ready;
  assign xfer    = gnt & free & i_rst_n;
  assign o_ready = xfer ? ({{(N-1){1'b0}}, 1'b1} << gidx) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_src   <= '0;
      ptr     <= SEL_W'(N - 1);
    end else if (xfer) begin
      o_valid <= 1'b1;
      o_data  <= gdata;
      o_src   <= gidx;
      if (i_mode) ptr <= gidx;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: an 8-channel and a 5-channel instance run side by side
// against a behavioural model of the output slot and the round-robin pointer.
module tb_mux_nx1_rr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [63:0] data_a;
  logic [7:0]  valid_a, rdy_a;
  logic        mode_a, ready_a, ovalid_a;
  logic [2:0]  sel_a, src_a;
  logic [7:0]  odata_a;

  logic [39:0] data_b;
  logic [4:0]  valid_b, rdy_b;
  logic        mode_b, ready_b, ovalid_b;
  logic [2:0]  sel_b, src_b;
  logic [7:0]  odata_b;

  mux_nx1_rr #(.WIDTH(8), .N(8)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data_a), .i_valid(valid_a), .o_ready(rdy_a),
    .i_mode(mode_a), .i_sel(sel_a), .o_data(odata_a), .o_valid(ovalid_a), .o_src(src_a),
    .i_ready(ready_a));

  mux_nx1_rr #(.WIDTH(8), .N(5)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data_b), .i_valid(valid_b), .o_ready(rdy_b),
    .i_mode(mode_b), .i_sel(sel_b), .o_data(odata_b), .o_valid(ovalid_b), .o_src(src_b),
    .i_ready(ready_b));

  int passed = 0;
  int total  = 0;

  // model state per instance: 0 = eight channels, 1 = five channels
  bit mv[2];
  int md[2];
  int ms[2];
  int mp[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int model_grant(input int n, input bit mode, input int sel,
                                     input logic [15:0] v, input int ptr);
    if (!mode) return (sel < n && v[sel]) ? sel : -1;
    for (int k = 1; k <= n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mv = '{0, 0};
    md = '{0, 0};
    ms = '{0, 0};
    mp = '{7, 4};
  endtask

  // called at a negedge with inputs already driven; ends at the following negedge
  task automatic step();
    int  g[2];
    bit  fr[2];
    #1;
    g[0]  = model_grant(8, mode_a, int'(sel_a), {8'b0, valid_a}, mp[0]);
    g[1]  = model_grant(5, mode_b, int'(sel_b), {11'b0, valid_b}, mp[1]);
    fr[0] = !mv[0] || ready_a;
    fr[1] = !mv[1] || ready_b;
    chk("ready_a", {56'b0, rdy_a}, (fr[0] && g[0] >= 0) ? (64'd1 << g[0]) : 64'd0);
    chk("ready_b", {59'b0, rdy_b}, (fr[1] && g[1] >= 0) ? (64'd1 << g[1]) : 64'd0);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (fr[d] && g[d] >= 0) begin
        mv[d] = 1'b1;
        md[d] = (d == 0) ? int'(data_a[g[d]*8 +: 8]) : int'(data_b[g[d]*8 +: 8]);
        ms[d] = g[d];
        if ((d == 0) ? mode_a : mode_b) mp[d] = g[d];
      end else if ((d == 0) ? ready_a : ready_b) begin
        mv[d] = 1'b0;
      end
    end
    @(negedge clk);
    chk("valid_a", {63'b0, ovalid_a}, {63'b0, mv[0]});
    chk("data_a",  {56'b0, odata_a},  64'(md[0]));
    chk("src_a",   {61'b0, src_a},    64'(ms[0]));
    chk("valid_b", {63'b0, ovalid_b}, {63'b0, mv[1]});
    chk("data_b",  {56'b0, odata_b},  64'(md[1]));
    chk("src_b",   {61'b0, src_b},    64'(ms[1]));
  endtask

  initial begin
    rst_n   = 1'b0;
    data_a  = 64'h0;  valid_a = '0; mode_a = 1'b0; sel_a = '0; ready_a = 1'b1;
    data_b  = 40'h0;  valid_b = '0; mode_b = 1'b0; sel_b = '0; ready_b = 1'b1;
    model_reset();
    #1;
    chk("rst_valid_a", {63'b0, ovalid_a}, 64'd0);
    chk("rst_ready_b", {59'b0, rdy_b}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // direct select of channel 5
    for (int k = 0; k < 8; k++) data_a[k*8 +: 8] = 8'(8'h10 + k);
    data_a[5*8 +: 8] = 8'hA5;
    valid_a = 8'b0010_0000; sel_a = 3'd5; mode_a = 1'b0;
    #1;
    chk("direct_ready", {56'b0, rdy_a}, 64'h20);
    #0;
    @(negedge clk);
    chk("direct_hold_valid", {63'b0, ovalid_a}, 64'd1);
    chk("direct_data", {56'b0, odata_a}, 64'hA5);
    chk("direct_src", {61'b0, src_a}, 64'd5);
    md[0] = 8'hA5; ms[0] = 5; mv[0] = 1'b1;
    valid_a = '0;
    step();

    // round-robin with every channel valid; ptr still at 7 from reset
    valid_a = 8'hFF; mode_a = 1'b1; ready_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rr_order", {61'b0, src_a}, 64'(i % 8));
    end

    // backpressure for three cycles, then resume at ptr+1
    ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ready", {56'b0, rdy_a}, 64'd0);
      chk("bp_src", {61'b0, src_a}, 64'd1);
    end
    ready_a = 1'b1;
    step();
    chk("bp_resume", {61'b0, src_a}, 64'd2);

    // five channels, only 1 and 4 valid, ptr at 4 after reset
    for (int k = 0; k < 5; k++) data_b[k*8 +: 8] = 8'(8'hB0 + k);
    valid_b = 5'b10010; mode_b = 1'b1; ready_b = 1'b1;
    valid_a = '0;
    step();
    chk("sparse_first", {61'b0, src_b}, 64'd1);
    step();
    chk("sparse_wrap", {61'b0, src_b}, 64'd4);
    mode_b = 1'b0; sel_b = 3'd6;
    step();
    chk("sel_oob_drain", {63'b0, ovalid_b}, 64'd0);
    chk("sel_oob_src_hold", {61'b0, src_b}, 64'd4);

    // mode switch while a beat is held under backpressure
    valid_a = 8'hFF; mode_a = 1'b1; ready_a = 1'b0;
    step();
    mode_a = 1'b0; sel_a = 3'd6;
    step();
    step();
    chk("switch_held", {61'b0, src_a}, 64'd3);
    ready_a = 1'b1;
    step();
    chk("switch_new", {61'b0, src_a}, 64'd6);

    // asynchronous reset mid-stream with a held beat
    mode_a = 1'b1; ready_a = 1'b0;
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'b0, ovalid_a}, 64'd0);
    chk("arst_data", {56'b0, odata_a}, 64'd0);
    chk("arst_src", {61'b0, src_a}, 64'd0);
    chk("arst_ready", {56'b0, rdy_a}, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; ready_a = 1'b1;
    step();
    chk("post_rst_first", {61'b0, src_a}, 64'd0);

    // randomized traffic on both instances
    for (int i = 0; i < 300; i++) begin
      data_a  = {$urandom, $urandom};
      data_b  = {8'($urandom), $urandom};
      valid_a = 8'($urandom);
      valid_b = 5'($urandom);
      mode_a  = ($urandom_range(0, 3) != 0);
      mode_b  = ($urandom_range(0, 3) != 0);
      sel_a   = 3'($urandom);
      sel_b   = 3'($urandom_range(0, 7));
      ready_a = ($urandom_range(0, 3) != 0);
      ready_b = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
